maze_move_ctrl: RTL and testbench

Sequencing controller for player movement in the maze game. Accepts one-cycle direction requests from the input conditioning logic and reads the current cell's wall bits from the synchronous maze ROM. It then commits or rejects the move and tracks position, move count and win status for the display logic. It is the only master of the maze ROM read port.

---
 rtl/maze_pkg.sv | 29 ++
 rtl/maze_next_cell.sv | 44 ++++
 rtl/maze_move_ctrl.sv | 108 ++++++++++
 tb/tb_maze_move_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze movement controller: directions, wall bit
// positions, FSM states and default grid constants.
package maze_pkg;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_E = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  localparam int WALL_N = 3;
  localparam int WALL_E = 2;
  localparam int WALL_S = 1;
  localparam int WALL_W = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WON   = 2'd3
  } state_t;

  localparam int DEF_GRID_BITS = 3;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_START_X   = 0;
  localparam int DEF_START_Y   = 0;
  localparam int DEF_GOAL_X    = 7;
  localparam int DEF_GOAL_Y    = 7;

endpackage

// File: rtl/maze_next_cell.sv
// Combinational neighbour lookup: target cell for a direction, and whether
// the step is blocked by a wall bit or by the grid edge.
module maze_next_cell
  import maze_pkg::*;
#(
  parameter int GRID_BITS = DEF_GRID_BITS
) (
  input  logic [GRID_BITS-1:0] pos_x,
  input  logic [GRID_BITS-1:0] pos_y,
  input  logic [1:0]           dir,
  input  logic [3:0]           wall,
  output logic [GRID_BITS-1:0] next_x,
  output logic [GRID_BITS-1:0] next_y,
  output logic                 blocked
);

  localparam logic [GRID_BITS-1:0] EDGE_MAX = {GRID_BITS{1'b1}};

  // The grid edge counts as a wall whatever the ROM says.
  always_comb begin
    next_x  = pos_x;
    next_y  = pos_y;
    blocked = 1'b0;
    case (dir)
      DIR_N: begin
        blocked = wall[WALL_N] || (pos_y == '0);
        next_y  = pos_y - 1'b1;
      end
      DIR_E: begin
        blocked = wall[WALL_E] || (pos_x == EDGE_MAX);
        next_x  = pos_x + 1'b1;
      end
      DIR_S: begin
        blocked = wall[WALL_S] || (pos_y == EDGE_MAX);
        next_y  = pos_y + 1'b1;
      end
      default: begin
        blocked = wall[WALL_W] || (pos_x == '0);
        next_x  = pos_x - 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/maze_move_ctrl.sv
// Player movement sequencer: reads the current cell's walls from the maze
// ROM, then commits or rejects the requested move and tracks score and win.
//
// state    | meaning
// ST_IDLE  | waiting for move_req; ROM read issued on request
// ST_READ  | ROM access in progress
// ST_CHECK | ROM data valid; commit or reject the move
// ST_WON   | goal reached; only restart/rst leaves
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int GRID_BITS = DEF_GRID_BITS,
  parameter int START_X   = DEF_START_X,
  parameter int START_Y   = DEF_START_Y,
  parameter int GOAL_X    = DEF_GOAL_X,
  parameter int GOAL_Y    = DEF_GOAL_Y,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_req,
  input  logic [1:0]             move_dir,
  input  logic                   restart,
  output logic                   rom_rd,
  output logic [2*GRID_BITS-1:0] rom_addr,
  input  logic [3:0]             rom_wall,
  output logic [GRID_BITS-1:0]   pos_x,
  output logic [GRID_BITS-1:0]   pos_y,
  output logic                   busy,
  output logic                   bump,
  output logic                   win,
  output logic [CNT_W-1:0]       moves
);

  localparam logic [GRID_BITS-1:0] START_XV = GRID_BITS'(START_X);
  localparam logic [GRID_BITS-1:0] START_YV = GRID_BITS'(START_Y);
  localparam logic [GRID_BITS-1:0] GOAL_XV  = GRID_BITS'(GOAL_X);
  localparam logic [GRID_BITS-1:0] GOAL_YV  = GRID_BITS'(GOAL_Y);

  state_t                 state;
  logic [1:0]             dir_q;
  logic [GRID_BITS-1:0]   next_x;
  logic [GRID_BITS-1:0]   next_y;
  logic                   blocked;

  maze_next_cell #(
    .GRID_BITS(GRID_BITS)
  ) u_next_cell (
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .dir    (dir_q),
    .wall   (rom_wall),
    .next_x (next_x),
    .next_y (next_y),
    .blocked(blocked)
  );

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state    <= ST_IDLE;
      dir_q    <= DIR_N;
      pos_x    <= START_XV;
      pos_y    <= START_YV;
      moves    <= '0;
      win      <= 1'b0;
      bump     <= 1'b0;
      busy     <= 1'b0;
      rom_rd   <= 1'b0;
      rom_addr <= {START_YV, START_XV};
    end else begin
      rom_rd <= 1'b0;
      bump   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (move_req) begin
            dir_q    <= move_dir;
            rom_rd   <= 1'b1;
            rom_addr <= {pos_y, pos_x};
            busy     <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: state <= ST_CHECK;
        ST_CHECK: begin
          busy <= 1'b0;
          if (blocked) begin
            bump  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            pos_x <= next_x;
            pos_y <= next_y;
            if (moves != '1) moves <= moves + 1'b1;
            // win rises together with the final position
            if (next_x == GOAL_XV && next_y == GOAL_YV) begin
              win   <= 1'b1;
              state <= ST_WON;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WON: win <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl with a behavioural synchronous maze ROM.
module tb_maze_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_req = 1'b0;
  logic [1:0] move_dir = 2'b00;
  logic       restart = 1'b0;
  logic       rom_rd;
  logic [5:0] rom_addr;
  logic [3:0] rom_wall = 4'h0;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic       busy;
  logic       bump;
  logic       win;
  logic [7:0] moves;

  logic [3:0] rom_mem [64];
  int nvec = 0;
  int nerr = 0;

  maze_move_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .move_req(move_req),
    .move_dir(move_dir),
    .restart (restart),
    .rom_rd  (rom_rd),
    .rom_addr(rom_addr),
    .rom_wall(rom_wall),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .busy    (busy),
    .bump    (bump),
    .win     (win),
    .moves   (moves)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) rom_wall <= rom_mem[rom_addr];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    move_req = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues a request and returns at the negedge after T+2 (results visible).
  task automatic issue(input logic [1:0] d);
    move_req = 1'b1;
    move_dir = d;
    @(negedge clk);
    move_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    nvec++;
    if ({pos_x, pos_y, moves, win, busy, bump, rom_rd, rom_addr} !== {3'd0, 3'd0, 8'd0, 4'b0000, 6'd0}) begin
      nerr++;
      $display("FAIL reset_state: got pos=(%0d,%0d) moves=%0d win=%b busy=%b bump=%b rd=%b addr=%0d, want all zero",
               pos_x, pos_y, moves, win, busy, bump, rom_rd, rom_addr);
    end
  endtask

  task automatic test_open_move();
    clear_rom();
    rom_mem[0] = 4'b1010;
    do_reset();
    move_req = 1'b1;
    move_dir = 2'b01;
    @(negedge clk);
    move_req = 1'b0;
    nvec++;
    if ({rom_rd, rom_addr, busy} !== {1'b1, 6'd0, 1'b1}) begin
      nerr++;
      $display("FAIL open_issue: got rd=%b addr=%0d busy=%b, want rd=1 addr=0 busy=1", rom_rd, rom_addr, busy);
    end
    @(negedge clk);
    nvec++;
    if ({rom_rd, busy, pos_x, pos_y} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
      nerr++;
      $display("FAIL open_read: got rd=%b busy=%b pos=(%0d,%0d), want rd=0 busy=1 pos=(0,0)", rom_rd, busy, pos_x, pos_y);
    end
    @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves, bump, busy} !== {3'd1, 3'd0, 8'd1, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL open_commit: got pos=(%0d,%0d) moves=%0d bump=%b busy=%b, want (1,0) 1 0 0", pos_x, pos_y, moves, bump, busy);
    end
  endtask

  task automatic test_walled_move();
    rom_mem[1] = 4'b0100;
    issue(2'b01);
    nvec++;
    if ({pos_x, pos_y, moves, bump} !== {3'd1, 3'd0, 8'd1, 1'b1}) begin
      nerr++;
      $display("FAIL walled: got pos=(%0d,%0d) moves=%0d bump=%b, want (1,0) 1 1", pos_x, pos_y, moves, bump);
    end
    @(negedge clk);
    nvec++;
    if (bump !== 1'b0) begin
      nerr++;
      $display("FAIL walled_bump_width: got bump=%b, want 0", bump);
    end
  endtask

  task automatic test_boundary();
    clear_rom();
    do_reset();
    issue(2'b00);
    nvec++;
    if ({pos_x, pos_y, moves, bump} !== {3'd0, 3'd0, 8'd0, 1'b1}) begin
      nerr++;
      $display("FAIL boundary_n: got pos=(%0d,%0d) moves=%0d bump=%b, want (0,0) 0 1", pos_x, pos_y, moves, bump);
    end
    issue(2'b11);
    nvec++;
    if ({pos_x, pos_y, moves, bump} !== {3'd0, 3'd0, 8'd0, 1'b1}) begin
      nerr++;
      $display("FAIL boundary_w: got pos=(%0d,%0d) moves=%0d bump=%b, want (0,0) 0 1", pos_x, pos_y, moves, bump);
    end
  endtask

  task automatic test_busy_drop();
    clear_rom();
    do_reset();
    move_req = 1'b1;
    move_dir = 2'b10;
    @(negedge clk);
    move_dir = 2'b01;
    @(negedge clk);
    move_req = 1'b0;
    @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves, busy} !== {3'd0, 3'd1, 8'd1, 1'b0}) begin
      nerr++;
      $display("FAIL busy_drop_first: got pos=(%0d,%0d) moves=%0d busy=%b, want (0,1) 1 0", pos_x, pos_y, moves, busy);
    end
    repeat (4) @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves, busy} !== {3'd0, 3'd1, 8'd1, 1'b0}) begin
      nerr++;
      $display("FAIL busy_drop_after: got pos=(%0d,%0d) moves=%0d busy=%b, want (0,1) 1 0", pos_x, pos_y, moves, busy);
    end
  endtask

  task automatic test_goal();
    clear_rom();
    do_reset();
    for (int i = 0; i < 7; i++) issue(2'b01);
    for (int i = 0; i < 6; i++) issue(2'b10);
    nvec++;
    if ({pos_x, pos_y, moves, win} !== {3'd7, 3'd6, 8'd13, 1'b0}) begin
      nerr++;
      $display("FAIL goal_pre: got pos=(%0d,%0d) moves=%0d win=%b, want (7,6) 13 0", pos_x, pos_y, moves, win);
    end
    issue(2'b10);
    nvec++;
    if ({pos_x, pos_y, moves, win} !== {3'd7, 3'd7, 8'd14, 1'b1}) begin
      nerr++;
      $display("FAIL goal_reach: got pos=(%0d,%0d) moves=%0d win=%b, want (7,7) 14 1", pos_x, pos_y, moves, win);
    end
    move_req = 1'b1;
    move_dir = 2'b11;
    @(negedge clk);
    move_req = 1'b0;
    nvec++;
    if ({rom_rd, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL won_ignore_issue: got rd=%b busy=%b, want 0 0", rom_rd, busy);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves, win, bump} !== {3'd7, 3'd7, 8'd14, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL won_frozen: got pos=(%0d,%0d) moves=%0d win=%b bump=%b, want (7,7) 14 1 0", pos_x, pos_y, moves, win, bump);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    nvec++;
    if ({pos_x, pos_y, moves, win, busy} !== {3'd0, 3'd0, 8'd0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL goal_restart: got pos=(%0d,%0d) moves=%0d win=%b busy=%b, want (0,0) 0 0 0", pos_x, pos_y, moves, win, busy);
    end
    issue(2'b01);
    nvec++;
    if ({pos_x, pos_y, moves} !== {3'd1, 3'd0, 8'd1}) begin
      nerr++;
      $display("FAIL restart_resume: got pos=(%0d,%0d) moves=%0d, want (1,0) 1", pos_x, pos_y, moves);
    end
  endtask

  task automatic test_restart_mid();
    clear_rom();
    do_reset();
    issue(2'b01);
    move_req = 1'b1;
    move_dir = 2'b01;
    @(negedge clk);
    move_req = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    nvec++;
    if ({pos_x, pos_y, moves, busy, rom_rd} !== {3'd0, 3'd0, 8'd0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL restart_mid_t1: got pos=(%0d,%0d) moves=%0d busy=%b rd=%b, want (0,0) 0 0 0", pos_x, pos_y, moves, busy, rom_rd);
    end
    @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves, busy, bump} !== {3'd0, 3'd0, 8'd0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL restart_mid_t2: got pos=(%0d,%0d) moves=%0d busy=%b bump=%b, want (0,0) 0 0 0", pos_x, pos_y, moves, busy, bump);
    end
  endtask

  task automatic test_restart_collision();
    clear_rom();
    do_reset();
    move_req = 1'b1;
    move_dir = 2'b01;
    restart = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
    restart = 1'b0;
    nvec++;
    if ({rom_rd, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL restart_collision_issue: got rd=%b busy=%b, want 0 0", rom_rd, busy);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if ({pos_x, pos_y, moves} !== {3'd0, 3'd0, 8'd0}) begin
      nerr++;
      $display("FAIL restart_collision_pos: got pos=(%0d,%0d) moves=%0d, want (0,0) 0", pos_x, pos_y, moves);
    end
  endtask

  task automatic test_back_to_back_saturate();
    clear_rom();
    do_reset();
    for (int i = 0; i < 255; i++) issue((i % 2 == 0) ? 2'b01 : 2'b11);
    nvec++;
    if ({pos_x, pos_y, moves} !== {3'd1, 3'd0, 8'd255}) begin
      nerr++;
      $display("FAIL sat_reach: got pos=(%0d,%0d) moves=%0d, want (1,0) 255", pos_x, pos_y, moves);
    end
    issue(2'b11);
    nvec++;
    if ({pos_x, pos_y, moves} !== {3'd0, 3'd0, 8'd255}) begin
      nerr++;
      $display("FAIL sat_hold: got pos=(%0d,%0d) moves=%0d, want (0,0) 255", pos_x, pos_y, moves);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_open_move();
    test_walled_move();
    test_boundary();
    test_busy_drop();
    test_goal();
    test_restart_mid();
    test_restart_collision();
    test_back_to_back_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
